mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers; sits directly

---
 rtl/mult_div_unit_pkg.sv | 26 ++
 rtl/mdu_iter_core.sv | 63 ++++++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit; the control unit
// also imports these to build its MFHI/MFLO/next-op stall.
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mdu_state_e;

   function automatic logic is_signed_op(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic is_div_op(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply or restoring divide.
// Exposes the post-step accumulator/shift register so the last step can be latched directly.
module mdu_iter_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         last,
   output logic [W-1:0] acc_nxt,
   output logic [W-1:0] sr_nxt
);
   localparam int CW = $clog2(W);

   logic [W-1:0]  acc, sr, dvs;
   logic          div_mode;
   logic [CW-1:0] cnt;
   logic [W:0]    sum, rsh;

   assign last = (cnt == CW'(W - 1));

   always_comb begin
      sum     = {1'b0, acc} + (sr[0] ? {1'b0, dvs} : '0);
      rsh     = {acc, sr[W-1]};
      acc_nxt = sum[W:1];
      sr_nxt  = {sum[0], sr[W-1:1]};
      if (div_mode) begin
         // restoring step: keep the shifted remainder unless the divisor fits
         if (rsh >= {1'b0, dvs}) begin
            acc_nxt = W'(rsh - {1'b0, dvs});
            sr_nxt  = {sr[W-2:0], 1'b1};
         end else begin
            acc_nxt = rsh[W-1:0];
            sr_nxt  = {sr[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         sr       <= '0;
         dvs      <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (load) begin
         acc      <= '0;
         sr       <= a;
         dvs      <= b;
         div_mode <= is_div;
         cnt      <= '0;
      end else if (step) begin
         acc <= acc_nxt;
         sr  <= sr_nxt;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and start/busy/done handshake.
//   state | meaning
//   IDLE  | no operation, HI/LO writable via MTHI/MTLO
//   RUN   | WIDTH iteration cycles, busy=1, HI/LO frozen
//   DONE  | one cycle, done=1, HI/LO hold the new result; may accept the next start
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   mdu_state_e         state, state_nxt;
   mdu_op_e            op_e;
   logic               accept, last;
   logic               sa, sb, op_div, div_zero;
   logic               neg_q, neg_r, div_q, dbz_q;
   logic [WIDTH-1:0]   abs_a, abs_b, a_raw;
   logic [WIDTH-1:0]   core_hi, core_lo, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      op_e     = mdu_op_e'(op);
      sa       = is_signed_op(op_e) & op_a[WIDTH-1];
      sb       = is_signed_op(op_e) & op_b[WIDTH-1];
      abs_a    = sa ? -op_a : op_a;
      abs_b    = sb ? -op_b : op_b;
      op_div   = is_div_op(op_e);
      div_zero = op_div && (op_b == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            accept    = start;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign dbz = done & dbz_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dbz_q <= 1'b0;
         a_raw <= '0;
      end else if (accept) begin
         div_q <= op_div;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         dbz_q <= div_zero;
         a_raw <= op_a;
      end
   end

   mdu_iter_core #(.W(WIDTH)) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (busy),
      .is_div  (op_div),
      .a       (abs_a),
      .b       (abs_b),
      .last    (last),
      .acc_nxt (core_hi),
      .sr_nxt  (core_lo)
   );

   // sign fix-up is applied to the final step's value so HI/LO load on DONE entry
   always_comb begin
      prod   = {core_hi, core_lo};
      if (neg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (dbz_q) begin
         res_hi = a_raw;
         res_lo = '1;
      end else if (div_q) begin
         res_hi = neg_r ? -core_hi : core_hi;
         res_lo = neg_q ? -core_lo : core_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (busy && last) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (!busy) begin
         if (hi_we) hi <= wr_data;
         if (lo_we) lo <= wr_data;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
   logic        hi_we = 1'b0, lo_we = 1'b0;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_hi = '0, exp_lo = '0, prev_hi, prev_lo, res_hi, res_lo;
   logic        res_dbz;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .op_a    (op_a),
      .op_b    (op_b),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .dbz     (dbz),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output logic rd);
      logic signed [63:0] sp;
      logic [63:0]        up;
      int                 si, sj;
      rd = 1'b0;
      rh = '0;
      rl = '0;
      case (o)
         2'b00: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            rh = sp[63:32];
            rl = sp[31:0];
         end
         2'b01: begin
            up = {32'b0, a} * {32'b0, b};
            rh = up[63:32];
            rl = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               rh = a;
               rl = 32'hFFFF_FFFF;
               rd = 1'b1;
            end else if (o == 2'b11) begin
               rl = a / b;
               rh = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               rl = 32'h8000_0000;
               rh = 32'd0;
            end else begin
               si = a;
               sj = b;
               rl = si / sj;
               rh = si % sj;
            end
         end
      endcase
   endtask

   // Drive one request for a single edge; optionally write HI alongside the accept.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit with_mthi);
      op      = o;
      op_a    = a;
      op_b    = b;
      start   = 1'b1;
      prev_hi = exp_hi;
      prev_lo = exp_lo;
      if (with_mthi) begin
         hi_we   = 1'b1;
         wr_data = $urandom;
         prev_hi = wr_data;
      end
      model(o, a, b, res_hi, res_lo, res_dbz);
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      op    = 2'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
   endtask

   // Runs until done (bounded), checks latency, busy span, hold and result.
   task automatic finish(input bit disturb);
      int cyc   = 1;
      int nbusy = 0;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         if (cyc == 16) begin
            chk("hold_hi", hi, prev_hi);
            chk("hold_lo", lo, prev_lo);
            chk("dbz_in_run", dbz, 0);
         end
         if (disturb && cyc == 10) begin
            start   = 1'b1;
            op      = 2'($urandom);
            op_a    = $urandom;
            op_b    = $urandom;
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            wr_data = $urandom;
         end
         tick();
         start = 1'b0;
         hi_we = 1'b0;
         lo_we = 1'b0;
         cyc++;
      end
      chk("done", done, 1);
      chk("latency", cyc, 33);
      chk("busy_cycles", nbusy, 32);
      chk("busy_in_done", busy, 0);
      chk("hi", hi, res_hi);
      chk("lo", lo, res_lo);
      chk("dbz", dbz, res_dbz);
      exp_hi = res_hi;
      exp_lo = res_lo;
   endtask

   initial begin
      int ndone;
      logic [31:0] ra, rb;
      logic [1:0]  ro;

      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", dbz, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      rst = 1'b0;
      tick();

      issue(2'b00, 32'hFFFF_FFFE, 32'd3, 0);          finish(0);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);  finish(0);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0);          finish(0);
      issue(2'b11, 32'd100, 32'd7, 0);                finish(0);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);  finish(0);
      issue(2'b11, 32'd5, 32'd0, 0);                  finish(0);
      issue(2'b11, 32'd9, 32'd3, 0);                  finish(0);
      tick();

      // disturbance mid-run, then back-to-back accept in the DONE cycle
      issue(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 0);  finish(1);
      issue(2'b10, 32'h8765_4321, 32'd13, 0);         finish(0);
      issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1001, 1);  finish(0);
      tick();

      hi_we   = 1'b1;
      wr_data = 32'hCAFE_0001;
      tick();
      hi_we   = 1'b0;
      exp_hi  = 32'hCAFE_0001;
      chk("mthi_idle", hi, exp_hi);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         issue(ro, ra, rb, $urandom_range(0, 3) == 0);
         finish($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1) tick();
      end

      // asynchronous reset in the middle of a multiply
      tick();
      hi_we   = 1'b1;
      lo_we   = 1'b1;
      wr_data = 32'h5555_AAAA;
      tick();
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      issue(2'b00, 32'd1000, 32'd2000, 0);
      repeat (9) tick();
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_hi", hi, 0);
      chk("rst_mid_lo", lo, 0);
      #1 rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("no_done_after_rst", ndone, 0);
      lo_we   = 1'b1;
      wr_data = 32'h0000_1234;
      tick();
      lo_we   = 1'b0;
      chk("mtlo_after_rst", lo, 32'h0000_1234);
      chk("hi_after_rst", hi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
